// File: rtl/io_sequencer_if.sv
// Bus between the control unit and the IN/OUT sequencer.
// It carries the instruction requests, the user inputs, and the sequencer results.
interface io_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int SW_W   = 16
);
   logic              io_in_req;
   logic              io_out_req;
   logic [SW_W-1:0]   switches;
   logic              confirm_btn;
   logic [DATA_W-1:0] out_data;
   logic              stall;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic [DATA_W-1:0] display_reg;
   logic              display_valid;
   logic              led_wait;

   modport master (
      output io_in_req, io_out_req, switches, confirm_btn, out_data,
      input  stall, in_data, in_valid, display_reg, display_valid, led_wait
   );

   modport slave (
      input  io_in_req, io_out_req, switches, confirm_btn, out_data,
      output stall, in_data, in_valid, display_reg, display_valid, led_wait
   );
endinterface

// File: rtl/io_sequencer.sv
// Stalls IN instructions until the user gives a debounced button press, then writes the switch value.
// OUT instructions latch a register value into a held display register.
module io_sequencer #(
   parameter int DATA_W          = 32,
   parameter int SW_W            = 16,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic           clock,
   input logic           reset,
   io_sequencer_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WAIT_PRESS = 2'd1;
   localparam logic [1:0] ACK        = 2'd2;
   localparam logic [1:0] RELEASE    = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_next;
   logic              sync_1;
   logic              sync_btn;
   logic              deb_lvl;
   logic              deb_lvl_q;
   logic [CW-1:0]     deb_cnt;
   logic              press;
   logic              out_take;
   logic [DATA_W-1:0] in_data_r;
   logic [DATA_W-1:0] display_r;
   logic              display_valid_r;

   // The debounced level changes only after the synchronized button holds a new value for DEBOUNCE_CYCLES cycles in a row.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1    <= 1'b0;
         sync_btn  <= 1'b0;
         deb_lvl   <= 1'b0;
         deb_lvl_q <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         sync_1    <= bus.confirm_btn;
         sync_btn  <= sync_1;
         deb_lvl_q <= deb_lvl;
         if (sync_btn == deb_lvl) begin
            deb_cnt <= '0;
         end else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_lvl <= ~deb_lvl;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign press = deb_lvl & ~deb_lvl_q;

   // An OUT is taken only where no IN competes for the same cycle.
   assign out_take = bus.io_out_req & ~bus.io_in_req &
                     ((state == IDLE) | (state == RELEASE));

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (bus.io_in_req) state_next = WAIT_PRESS;
         WAIT_PRESS: begin
            if (!bus.io_in_req) state_next = IDLE;
            else if (press)     state_next = ACK;
         end
         ACK:        state_next = RELEASE;
         RELEASE:    if (!deb_lvl) state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         in_data_r       <= '0;
         display_r       <= '0;
         display_valid_r <= 1'b0;
      end else begin
         state <= state_next;
         if (state == WAIT_PRESS && bus.io_in_req && press)
            in_data_r <= DATA_W'(bus.switches);
         if (out_take) begin
            display_r       <= bus.out_data;
            display_valid_r <= 1'b1;
         end
      end
   end

   // Reset masks the decoded outputs right away instead of waiting for the next edge.
   assign bus.stall = ~reset & (((state == IDLE) & bus.io_in_req) |
                                (state == WAIT_PRESS) |
                                ((state == RELEASE) & bus.io_in_req));
   assign bus.led_wait      = ~reset & (state == WAIT_PRESS);
   assign bus.in_valid      = ~reset & (state == ACK);
   assign bus.in_data       = in_data_r;
   assign bus.display_reg   = display_r;
   assign bus.display_valid = display_valid_r;
endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer with DEBOUNCE_CYCLES=4.
// Expected values are worked out by hand from the button and FSM timing.
module tb_io_sequencer;
   localparam int DATA_W = 32;
   localparam int SW_W   = 16;

   logic clock;
   logic reset;
   int   testsRun;
   int   testsFailed;
   int   validCount;
   int   stallHits;
   int   cycles;
   int   snap;

   io_sequencer_if #(.DATA_W(DATA_W), .SW_W(SW_W)) bus ();

   io_sequencer #(.DATA_W(DATA_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count write strobes and stall cycles on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (bus.in_valid) validCount++;
      if (bus.stall)    stallHits++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic in_req, input logic out_req, input logic [15:0] sw,
                                input logic btn, input logic [31:0] odata);
      bus.io_in_req   = in_req;
      bus.io_out_req  = out_req;
      bus.switches    = sw;
      bus.confirm_btn = btn;
      bus.out_data    = odata;
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic waitValid(input string tag, input int maxCycles, output int taken);
      logic found;
      found = 1'b0;
      taken = 0;
      for (int i = 0; i < maxCycles; i++) begin
         tick();
         if (bus.in_valid) begin
            found = 1'b1;
            taken = i + 1;
            break;
         end
      end
      checkOutput({tag, "_seen"}, {31'd0, found}, 32'd1);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      validCount  = 0;
      stallHits   = 0;

      // 1. reset values, then one clean IN
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 32'h0);
      #2;
      checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("rst_led", {31'd0, bus.led_wait}, 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 32'h0);
      tick(2);
      reset = 1'b0;
      #1;
      checkOutput("rst_in_data", bus.in_data, 32'h0);
      checkOutput("rst_in_valid", {31'd0, bus.in_valid}, 32'd0);
      checkOutput("rst_display", bus.display_reg, 32'h0);
      checkOutput("rst_disp_valid", {31'd0, bus.display_valid}, 32'd0);
      tick();
      validCount = 0;
      applyStimulus(1'b1, 1'b0, 16'hA5A5, 1'b0, 32'h0);
      #1;
      checkOutput("t1_stall_first", {31'd0, bus.stall}, 32'd1);
      tick();
      checkOutput("t1_led_wait", {31'd0, bus.led_wait}, 32'd1);
      bus.confirm_btn = 1'b1;
      waitValid("t1", 40, cycles);
      checkOutput("t1_latency_ok", {31'd0, cycles >= 6}, 32'd1);
      checkOutput("t1_in_data", bus.in_data, 32'h0000A5A5);
      checkOutput("t1_ack_stall", {31'd0, bus.stall}, 32'd0);
      bus.io_in_req = 1'b0;
      bus.switches  = 16'hFFFF;
      tick();
      bus.confirm_btn = 1'b0;
      tick(12);
      checkOutput("t1_one_valid", validCount, 32'd1);
      checkOutput("t1_data_held", bus.in_data, 32'h0000A5A5);

      // 2. glitchy press is rejected, stable press is accepted
      validCount = 0;
      applyStimulus(1'b1, 1'b0, 16'h1234, 1'b0, 32'h0);
      tick();
      for (int k = 0; k < 6; k++) begin
         bus.confirm_btn = 1'b1;
         tick(2);
         bus.confirm_btn = 1'b0;
         tick();
      end
      tick(6);
      checkOutput("t2_glitch_no_valid", validCount, 32'd0);
      checkOutput("t2_still_waiting", {31'd0, bus.led_wait}, 32'd1);
      bus.confirm_btn = 1'b1;
      waitValid("t2", 40, cycles);
      checkOutput("t2_in_data", bus.in_data, 32'h00001234);
      bus.io_in_req = 1'b0;
      tick();
      bus.confirm_btn = 1'b0;
      tick(12);
      checkOutput("t2_one_valid", validCount, 32'd1);

      // 3. OUT in IDLE
      stallHits = 0;
      applyStimulus(1'b0, 1'b1, 16'h0, 1'b0, 32'hDEADBEEF);
      tick();
      bus.io_out_req = 1'b0;
      #1;
      checkOutput("t3_display", bus.display_reg, 32'hDEADBEEF);
      checkOutput("t3_disp_valid", {31'd0, bus.display_valid}, 32'd1);
      tick(2);
      checkOutput("t3_no_stall", stallHits, 32'd0);

      // 4. back-to-back IN with the button still held
      validCount = 0;
      applyStimulus(1'b1, 1'b0, 16'h0011, 1'b0, 32'h0);
      tick();
      bus.confirm_btn = 1'b1;
      waitValid("t4a", 40, cycles);
      checkOutput("t4_first_data", bus.in_data, 32'h00000011);
      bus.switches = 16'h0022;
      tick();
      checkOutput("t4_release_stall", {31'd0, bus.stall}, 32'd1);
      checkOutput("t4_release_led", {31'd0, bus.led_wait}, 32'd0);
      tick(5);
      checkOutput("t4_held_stall", {31'd0, bus.stall}, 32'd1);
      checkOutput("t4_held_no_valid", validCount, 32'd1);
      bus.confirm_btn = 1'b0;
      tick(12);
      checkOutput("t4_waiting_again", {31'd0, bus.led_wait}, 32'd1);
      bus.confirm_btn = 1'b1;
      waitValid("t4b", 40, cycles);
      checkOutput("t4_second_data", bus.in_data, 32'h00000022);
      bus.io_in_req = 1'b0;
      tick();
      bus.confirm_btn = 1'b0;
      tick(12);
      checkOutput("t4_two_valid", validCount, 32'd2);

      // 5. interrupted IN, then IN and OUT together
      validCount = 0;
      applyStimulus(1'b1, 1'b0, 16'h7777, 1'b0, 32'h0);
      tick();
      bus.io_in_req = 1'b0;
      tick();
      checkOutput("t5_drop_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("t5_drop_led", {31'd0, bus.led_wait}, 32'd0);
      checkOutput("t5_data_kept", bus.in_data, 32'h00000022);
      applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0, 32'h12345678);
      #1;
      checkOutput("t5_both_stall", {31'd0, bus.stall}, 32'd1);
      tick();
      checkOutput("t5_both_led", {31'd0, bus.led_wait}, 32'd1);
      checkOutput("t5_display_kept", bus.display_reg, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 16'h7777, 1'b0, 32'h0);
      tick(2);
      checkOutput("t5_no_valid", validCount, 32'd0);

      // 6. asynchronous reset with the button mid-debounce
      applyStimulus(1'b1, 1'b0, 16'h00C3, 1'b0, 32'h0);
      tick();
      bus.confirm_btn = 1'b1;
      tick(4);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t6_stall_now", {31'd0, bus.stall}, 32'd0);
      checkOutput("t6_led_now", {31'd0, bus.led_wait}, 32'd0);
      checkOutput("t6_display_clr", bus.display_reg, 32'h0);
      checkOutput("t6_disp_valid_clr", {31'd0, bus.display_valid}, 32'd0);
      checkOutput("t6_in_data_clr", bus.in_data, 32'h0);
      tick(2);
      reset = 1'b0;
      waitValid("t6", 40, cycles);
      checkOutput("t6_full_debounce", {31'd0, cycles >= 6}, 32'd1);
      checkOutput("t6_in_data", bus.in_data, 32'h000000C3);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
